mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared single-port 8-bit data memory.
- Port 0 is the fetch side and port 1 is the load/store side.
- Each transaction is latched, the block drives exactly one of MemReadEn/MemWriteEn for one cycle, and read data is returned to the winner with a valid pulse.
- The memory sees at most one command per transaction and never both enables in the same cycle.

Parameters:
AW, 8, address width passed unchanged to the memory Address port
DW, 8, data width of WriteData/ReadData and requester data buses

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
req0  input  1  port 0 request; held high until ack0 is seen
we0  input  1  port 0 write (1) / read (0); valid with req0
addr0  input  AW  port 0 address
wdata0  input  DW  port 0 write data
ack0  output  1  port 0 request accepted (1-cycle pulse)
rvalid0  output  1  port 0 read data valid (1-cycle pulse)
rdata0  output  DW  port 0 read data, held until next port 0 read
req1/we1/addr1/wdata1/ack1/rvalid1/rdata1: same as the port 0 signals, for port 1
mem_addr  output  AW  to memory Address
mem_wdata  output  DW  to memory WriteData
mem_rd_en  output  1  to memory MemReadEn
mem_wr_en  output  1  to memory MemWriteEn
mem_rdata  input  DW  from memory ReadData (registered in memory, valid 1 cycle after mem_rd_en)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, last_grant=1 so port 0 wins first.
  - All ack/rvalid/mem enables are 0; rdata0/rdata1 are 0; mem_addr/mem_wdata are 0.
- All outputs are registered.
- FSM states are IDLE, ISSUE and RESP.
- IDLE:
  - If neither request is active, stay in IDLE.
  - If only one reqN is active, that port wins.
  - If both are active, the winner is the port != last_grant.
  - On the edge, latch winner id, we, addr and wdata. Set last_grant=winner. Go to ISSUE.
- ISSUE (1 cycle):
  - ackN=1 for the winner only.
  - mem_addr and mem_wdata carry the latched values.
  - mem_wr_en=we or mem_rd_en=!we; exactly one is high.
  - Next state: write -> IDLE; read -> RESP.
- RESP (1 cycle):
  - mem_rdata is valid in this cycle.
  - On the edge, capture rdataN<=mem_rdata and pulse rvalidN=1 in the following cycle. Go to IDLE.
- Cycle counts from the ISSUE cycle:
  - Write: memory updated at the end of ISSUE; 2-cycle occupancy (IDLE+ISSUE).
  - Read: rvalid asserted 2 cycles after ack; 3-cycle occupancy.
- Requester rules:
  - The requester must deassert or update reqN on the edge after ackN.
  - IDLE re-samples only after ISSUE/RESP, so a held req is never double-granted.
  - The requester must not change we/addr/wdata while reqN=1 and ackN not yet seen.
- Fairness: with both requesting continuously, grants strictly alternate 0,1,0,1…
- A req arriving during ISSUE/RESP waits; no request is lost or reordered within a port.
- rdataN holds its value across write transactions and the other port's reads.
- Reset mid-transaction: state returns to IDLE immediately.
  - Any pending read is dropped with no rvalid.
  - A write in ISSUE may or may not have committed; software must reissue it.
- The memory's own reset is active-high; the integration level connects it to !rst.
- Address is not range-checked; it is passed through unchanged.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2).
  - port id constants PORT_FETCH=0, PORT_LS=1.
  - default AW/DW.
- One natural sub-module, rr_arbiter2: two-input round-robin select with a last_grant register, returning winner id and grant_valid.
- The FSM, latches and memory drive stay in mem_port_arbiter.

Test Plan:
- Reset: hold rst=0 then release; all outputs 0; the first simultaneous req0/req1 grants port 0 (ack0 high, ack1 low).
- Single write then read:
  - Port 1 writes addr=8'h05, wdata=8'hA7 (ack1 after 1 cycle, mem_wr_en for exactly 1 cycle).
  - Then port 1 reads addr=8'h05: rvalid1 2 cycles after ack1, rdata1=8'hA7.
- Contention: req0 and req1 both held high for 4 reads each to distinct addresses; grants alternate 0,1,0,1…; each rvalid is paired with the correct port and data.
- Exclusivity: random traffic on both ports for 1000 cycles; assert mem_rd_en & mem_wr_en never both 1; assert each ack is followed by exactly one memory command.
- Isolation: port 0 reads 8'h02 (data 8'h11) and port 1 then writes 8'h02=8'h22; rdata0 stays 8'h11 until port 0's next read returns 8'h22.
- Reset mid-read: drive rst=0 during RESP; no rvalid pulse follows, state is IDLE, and a subsequent read completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port data memory arbiter: FSM encoding,
// requester port identifiers and default bus widths.
package mem_port_arbiter_pkg;

    localparam int DEFAULT_AW = 8;
    localparam int DEFAULT_DW = 8;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LS    = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Two-input round-robin select; the last_grant register only moves when the
// caller actually takes the grant, so an unused decision does not rotate priority.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       winner_o,
    output logic       grant_valid_o
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        grant_valid_o = |req_i;
        if (&req_i) begin
            winner_o = ~last_grant_q;
        end else if (req_i[1]) begin
            winner_o = PORT_LS;
        end else begin
            winner_o = PORT_FETCH;
        end
        last_grant_d = advance_i ? winner_o : last_grant_q;
    end

    // Starting from the load/store side makes fetch win the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= PORT_LS;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer for the shared single-port data memory: latches one
// request at a time, issues exactly one memory command and returns read data.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd_en,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_rdata
);

    state_e        state_q, state_d;
    logic          id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic winner, grantValid, advance, selWe;

    // Requests are only presented to the arbiter in IDLE, so a request still
    // held during ISSUE/RESP can never be granted twice.
    rr_arbiter2 u_rr (
        .clk_i        (clk),
        .rst_ni       (rst),
        .req_i        ({req1 & (state_q == IDLE), req0 & (state_q == IDLE)}),
        .advance_i    (advance),
        .winner_o     (winner),
        .grant_valid_o(grantValid)
    );

    assign selWe = (winner == PORT_LS) ? we1 : we0;

    // Outputs are computed for the next cycle so that every port is a flop.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        advance   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grantValid) begin
                    advance = 1'b1;
                    id_d    = winner;
                    we_d    = selWe;
                    addr_d  = (winner == PORT_LS) ? addr1 : addr0;
                    wdata_d = (winner == PORT_LS) ? wdata1 : wdata0;
                    ack0_d  = (winner == PORT_FETCH);
                    ack1_d  = (winner == PORT_LS);
                    wr_en_d = selWe;
                    rd_en_d = ~selWe;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                if (id_q == PORT_LS) begin
                    rdata1_d  = mem_rdata;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_rdata;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            id_q      <= PORT_FETCH;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_rd_en = rd_en_q;
    assign mem_wr_en = wr_en_q;

endmodule
